// File: rtl/div_iter_if.sv
// div_iter_if: hazard-to-divider handshake bundle (start/operands in, ready/busy/result out).
interface div_iter_if #(parameter int WIDTH = 32);
    logic                 div_start;
    logic                 div_signed;
    logic [WIDTH-1:0]     div_opa;
    logic [WIDTH-1:0]     div_opb;
    logic                 div_ready;
    logic                 div_busy;
    logic [2*WIDTH-1:0]   div_result;
    modport master (
        output div_start, div_signed, div_opa, div_opb,
        input  div_ready, div_busy, div_result
    );
    modport slave (
        input  div_start, div_signed, div_opa, div_opb,
        output div_ready, div_busy, div_result
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring DIV/DIVU, one quotient bit per cycle, result {HI=rem, LO=quo}.
// Define DIV_ZERO_FAST_EN to shortcut a zero divisor through a one-cycle ZERO state.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_iter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef DIV_ZERO_FAST_EN
    localparam logic [1:0] ZERO = 2'd3;
`endif
    logic [1:0]       state;
    logic [WIDTH-1:0] dvd, rem, bmag;
    logic             qsign, rsign;
    logic [CW-1:0]    cnt;
    logic             sa, sb, ge;
    logic [WIDTH-1:0] amag_in, bmag_in, diff, rem_n, dvd_n, q_fix, r_fix;
    logic [WIDTH:0]   partial;
    logic [2*WIDTH-1:0] result;
    // dvd doubles as the quotient: dividend bits shift out the top as quotient bits shift in
    always_comb begin
        sa      = bus.div_signed & bus.div_opa[WIDTH-1];
        sb      = bus.div_signed & bus.div_opb[WIDTH-1];
        amag_in = sa ? -bus.div_opa : bus.div_opa;
        bmag_in = sb ? -bus.div_opb : bus.div_opb;
        partial = {rem, dvd[WIDTH-1]};
        ge      = partial >= {1'b0, bmag};
        diff    = partial[WIDTH-1:0] - bmag;
        rem_n   = ge ? diff : partial[WIDTH-1:0];
        dvd_n   = {dvd[WIDTH-2:0], ge};
        q_fix   = qsign ? -dvd_n : dvd_n;
        r_fix   = rsign ? -rem_n : rem_n;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            dvd    <= '0;
            rem    <= '0;
            bmag   <= '0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (bus.div_start) begin
                    dvd   <= amag_in;
                    bmag  <= bmag_in;
                    qsign <= sa ^ sb;
                    rsign <= sa;
                    rem   <= '0;
                    cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
                    state <= (bmag_in == '0) ? ZERO : BUSY;
`else
                    state <= BUSY;
`endif
                end
                BUSY: if (!bus.div_start) begin
                    state <= IDLE;
                end else begin
                    rem <= rem_n;
                    dvd <= dvd_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        result <= {r_fix, q_fix};
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                // same values the full iteration would produce for a zero divisor
                ZERO: begin
                    result <= {(rsign ? -dvd : dvd), (qsign ? WIDTH'(1) : {WIDTH{1'b1}})};
                    state  <= DONE;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.div_ready  = state == DONE;
    assign bus.div_busy   = state != IDLE;
    assign bus.div_result = result;
endmodule
